axi3_slave_wr_path: RTL and testbench

- Write half of the AXI3 slave under test. Sits directly downstream of the AXI3 interface bundle and consumes its AW, W and B channels.
- Accepts one write burst at a time. Generates per-beat addresses for FIXED, INCR and WRAP bursts, and exposes the current beat address as next_addrwr.
- Writes byte lanes into an internal memory and returns one B response per burst.
- The read path is a separate block; a debug read port allows direct memory checks.

---
 rtl/axi3_slave_wr_path.sv | 169 ++++++++++++++++
 tb/tb_axi3_slave_wr_path.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi3_slave_wr_path.sv
// AXI3 slave write path: one burst at a time, FIXED/INCR/WRAP beat addressing,
// byte-lane writes into a local memory, and a single B response per burst.

module axi3_wr_byte_lane #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [7:0]       wbyte,
  input  logic [IDX_W-1:0] ridx,
  output logic [7:0]       rbyte
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[widx] <= wbyte;

  assign rbyte = mem[ridx];
endmodule

module axi3_slave_wr_path #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        awid,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [3:0]        wid,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic [ADDR_W-1:0] next_addrwr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_rdata
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int DEPTH     = MEM_BYTES / NUM_LANES;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } aw_req_t;

  state_t            state_q, state_d;
  aw_req_t           req_q;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [3:0]        cnt_q;
  logic              err_q;
  logic              awready_q;

  logic aw_hs, w_hs, aw_err, beat_last, in_range, id_ok, beat_we, beat_err;
  logic [ADDR_W-1:0] bytes, aligned, incr, total, wrap_low, wrap_next;
  logic [NUM_LANES-1:0]       lane_we;
  logic [NUM_LANES-1:0][7:0]  lane_rdata;
  logic unused_bits;

  assign aw_hs  = awvalid && awready_q;
  assign w_hs   = wvalid && wready;
  assign aw_err = (awsize > 3'd2) || (awburst == 2'b11) ||
                  ((awburst == 2'b10) && !(awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));

  assign beat_last = (cnt_q == req_q.len);
  assign in_range  = (addr_q < MEM_LIMIT);
  assign id_ok     = (wid == req_q.id);
  assign beat_we   = w_hs && !err_q && id_ok && in_range;
  assign beat_err  = !id_ok || !in_range || (wlast != beat_last);

  // WRAP window is (len+1) beats; the first beat may be unaligned.
  assign bytes     = ADDR_W'(1) << req_q.size;
  assign aligned   = addr_q & ~(bytes - ADDR_W'(1));
  assign incr      = aligned + bytes;
  assign total     = ADDR_W'({1'b0, req_q.len} + 5'd1) << req_q.size;
  assign wrap_low  = aligned & ~(total - ADDR_W'(1));
  assign wrap_next = (incr == wrap_low + total) ? wrap_low : incr;

  always_comb begin
    addr_next = addr_q;
    unique case (req_q.burst)
      2'b01:   addr_next = incr;
      2'b10:   addr_next = wrap_next;
      default: addr_next = addr_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wready  = 1'b0;
    bvalid  = 1'b0;
    unique case (state_q)
      IDLE: if (aw_hs) state_d = DATA;
      DATA: begin
        wready = 1'b1;
        if (wvalid && beat_last) state_d = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // awready is registered so it stays low for one cycle after a B handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      req_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= (state_q == IDLE) && !aw_hs;
      if (aw_hs) begin
        req_q  <= '{awid, awlen, awsize, awburst};
        addr_q <= awaddr;
        cnt_q  <= '0;
        err_q  <= aw_err;
      end else if (w_hs) begin
        addr_q <= addr_next;
        cnt_q  <= cnt_q + 4'd1;
        err_q  <= err_q | beat_err;
      end
    end
  end

  assign awready     = awready_q;
  assign bid         = req_q.id;
  assign bresp       = (state_q == RESP && err_q) ? 2'b10 : 2'b00;
  assign next_addrwr = addr_q;

  assign lane_we = {NUM_LANES{beat_we}} & wstrb;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    axi3_wr_byte_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .widx  (addr_q[IDX_W+1:2]),
      .wbyte (wdata[8*i +: 8]),
      .ridx  (dbg_addr[IDX_W+1:2]),
      .rbyte (lane_rdata[i])
    );
  end

  assign dbg_rdata   = (dbg_addr < MEM_LIMIT) ? DATA_W'(lane_rdata) : '0;
  assign unused_bits = ^dbg_addr[1:0];
endmodule

// File: tb/tb_axi3_slave_wr_path.sv
// Bench for axi3_slave_wr_path: directed vector table, hand sequences for
// simultaneous AW/W and mid-burst reset, then randomized bursts vs a byte-array model.

module tb_axi3_slave_wr_path;
  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [3:0]  awid = '0, awlen = '0;
  logic [2:0]  awsize = '0;
  logic [31:0] awaddr = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [31:0] next_addrwr, dbg_addr = '0, dbg_rdata;

  int checks = 0, errors = 0;
  logic [7:0]  mm [MEM_BYTES];
  logic [31:0] beat_dat [16];
  logic [3:0]  beat_stb [16];
  logic [31:0] cap_addr [16];
  logic [1:0]  cap_bresp;
  logic [3:0]  cap_bid;

  typedef struct {
    string            nm;
    logic [3:0]       id;
    logic [31:0]      a;
    logic [3:0]       len;
    logic [2:0]       sz;
    logic [1:0]       bt;
    logic [3:0][31:0] d;
    logic [3:0][3:0]  s;
    int               bad_wid, bad_last, bdelay;
    logic [1:0]       exp_resp;
    logic             chk_a;
    logic [3:0][31:0] exp_a;
  } vec_t;

  always #5 clk = ~clk;

  axi3_slave_wr_path #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awaddr(awaddr), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .next_addrwr(next_addrwr), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got=timeout exp=handshake", nm);
  endtask

  // Beat address straight from the AXI burst rules.
  function automatic logic [31:0] mdl_addr(input logic [31:0] a, input int len,
                                           input int sz, input logic [1:0] bt, input int n);
    logic [31:0] by, al, tot, low;
    by  = 32'd1 << sz;
    al  = a - (a % by);
    tot = by * (len + 1);
    low = al - (al % tot);
    case (bt)
      2'b01:   return (n == 0) ? a : al + by * n;
      2'b10:   return (n == 0) ? a : low + (al - low + by * n) % tot;
      default: return a;
    endcase
  endfunction

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    int n = 0;
    logic hs;
    awvalid = 1'b1; awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt;
    do begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1; n++;
    end while (!hs && n < 100);
    if (!hs) timeout("aw_handshake");
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, input logic [3:0] id,
                        input logic last, output logic [31:0] a);
    int n = 0;
    logic hs;
    wvalid = 1'b1; wdata = d; wstrb = s; wid = id; wlast = last;
    do begin
      @(negedge clk); hs = wready; a = next_addrwr;
      @(posedge clk); #1; n++;
    end while (!hs && n < 100);
    if (!hs) timeout("w_handshake");
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_phase(input int bdelay);
    int n = 0;
    logic [3:0] id0;
    logic [1:0] r0;
    bready = (bdelay == 0);
    @(negedge clk);
    chk("b_latency", bvalid, 1);
    id0 = bid; r0 = bresp;
    while (!bready) begin
      @(posedge clk); #1; n++;
      if (n >= bdelay) bready = 1'b1;
      @(negedge clk);
      chk("b_valid_hold", bvalid, 1);
      chk("b_id_hold", bid, id0);
      chk("b_resp_hold", bresp, r0);
      chk("aw_blocked", awready, 0);
    end
    cap_bid = id0; cap_bresp = r0;
    @(posedge clk); #1; bready = 1'b0;
    @(negedge clk);
    chk("b_one_cycle", bvalid, 0);
    chk("dead_cycle", awready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("aw_reopen", awready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_burst(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                          input logic [2:0] sz, input logic [1:0] bt, input int bad_wid,
                          input int bad_last, input int gap_max, input int bdelay);
    bit lerr, err;
    logic [31:0] ea, ga;
    int L;
    L    = len;
    lerr = (sz > 2) || (bt == 2'b11) || (bt == 2'b10 && !(len inside {1, 3, 7, 15}));
    err  = lerr;
    aw_send(id, a, len, sz, bt);
    for (int b = 0; b <= L; b++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      w_beat(beat_dat[b], beat_stb[b], (b == bad_wid) ? id ^ 4'h1 : id,
             (b == L) ^ (b == bad_last), ga);
      cap_addr[b] = ga;
      ea = mdl_addr(a, L, sz, bt, b);
      if (!lerr) chk("beat_addr", ga, ea);
      if (!err && b != bad_wid && ea < MEM_BYTES)
        for (int i = 0; i < 4; i++)
          if (beat_stb[b][i]) mm[int'(ea & ~32'd3) + i] = beat_dat[b][8*i +: 8];
      if (b == bad_wid || ea >= MEM_BYTES || b == bad_last) err = 1;
    end
    b_phase(bdelay);
    chk("bresp", cap_bresp, err ? 2'b10 : 2'b00);
    chk("bid", cap_bid, id);
  endtask

  task automatic check_mem(input string nm);
    logic [31:0] e, g_bad, e_bad;
    int bad = -1;
    for (int w = 0; w < MEM_BYTES / 4; w++) begin
      dbg_addr = w * 4 + $urandom_range(3, 0);
      #1;
      e = {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]};
      if (dbg_rdata !== e && bad < 0) begin bad = w; g_bad = dbg_rdata; e_bad = e; end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s word %0h got=%h exp=%h", nm, bad * 4, g_bad, e_bad);
    end
    @(posedge clk); #1;
  endtask

  task automatic dbg_chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    dbg_addr = a; #1;
    chk(nm, dbg_rdata, e);
  endtask

  initial begin
    vec_t v [13];
    logic [3:0]  rid, rlen;
    logic [2:0]  rsz;
    logic [1:0]  rbt;
    logic [31:0] ra, ga;
    int rbw, rbl;
    bit seen_b;

    v[0]  = '{"incr", 4'd3, 32'h10, 4'd3, 3'd2, 2'd1,
              {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16'hFFFF,
              -1, -1, 0, 2'b00, 1'b1, {32'h1C, 32'h18, 32'h14, 32'h10}};
    v[1]  = '{"wrap", 4'd7, 32'h38, 4'd3, 3'd2, 2'd2,
              {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, 16'hFFFF,
              -1, -1, 1, 2'b00, 1'b1, {32'h34, 32'h30, 32'h3C, 32'h38}};
    v[2]  = '{"fixed", 4'd1, 32'h40, 4'd1, 3'd2, 2'd0,
              {32'h0, 32'h0, 32'hBBBBBBBB, 32'hAAAAAAAA}, 16'hFF21,
              -1, -1, 0, 2'b00, 1'b1, {32'h0, 32'h0, 32'h40, 32'h40}};
    v[3]  = '{"size3", 4'd2, 32'h80, 4'd3, 3'd3, 2'd1,
              {32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF}, 16'hFFFF,
              -1, -1, 0, 2'b10, 1'b0, 128'h0};
    v[4]  = '{"oor", 4'd4, 32'h3FC, 4'd1, 3'd2, 2'd1,
              {32'h0, 32'h0, 32'hC3C3C3C3, 32'h5A5A5A5A}, 16'hFFFF,
              -1, -1, 0, 2'b10, 1'b1, {32'h0, 32'h0, 32'h400, 32'h3FC}};
    v[5]  = '{"early_last", 4'd5, 32'h60, 4'd2, 3'd2, 2'd1,
              {32'h0, 32'h77777777, 32'h99999999, 32'h66666666}, 16'hFFFF,
              -1, 0, 0, 2'b10, 1'b1, {32'h0, 32'h68, 32'h64, 32'h60}};
    v[6]  = '{"backpressure", 4'd9, 32'h90, 4'd0, 3'd2, 2'd1,
              {32'h0, 32'h0, 32'h0, 32'h13579BDF}, 16'hFFFF,
              -1, -1, 5, 2'b00, 1'b1, {32'h0, 32'h0, 32'h0, 32'h90}};
    v[7]  = '{"wrap_badlen", 4'd6, 32'hA0, 4'd2, 3'd2, 2'd2,
              {32'h0, 32'h1, 32'h2, 32'h3}, 16'hFFFF,
              -1, -1, 0, 2'b10, 1'b0, 128'h0};
    v[8]  = '{"reserved", 4'd8, 32'hB0, 4'd1, 3'd2, 2'd3,
              {32'h0, 32'h0, 32'h5, 32'h6}, 16'hFFFF,
              -1, -1, 0, 2'b10, 1'b0, 128'h0};
    v[9]  = '{"wid_bad", 4'd10, 32'hC0, 4'd1, 3'd2, 2'd1,
              {32'h0, 32'h0, 32'hCCCC0001, 32'hCCCC0000}, 16'hFFFF,
              1, -1, 0, 2'b00 | 2'b10, 1'b1, {32'h0, 32'h0, 32'hC4, 32'hC0}};
    v[10] = '{"incr_byte", 4'd11, 32'hD1, 4'd3, 3'd0, 2'd1,
              {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101}, 16'h8421,
              -1, -1, 0, 2'b00, 1'b1, {32'hD4, 32'hD3, 32'hD2, 32'hD1}};
    v[11] = '{"incr_unaligned", 4'd12, 32'hE2, 4'd2, 3'd2, 2'd1,
              {32'h0, 32'hE8E8E8E8, 32'hE4E4E4E4, 32'hE0E0E0E0}, 16'hFFFF,
              -1, -1, 0, 2'b00, 1'b1, {32'h0, 32'hE8, 32'hE4, 32'hE2}};
    v[12] = '{"wrap_half", 4'd14, 32'h106, 4'd1, 3'd1, 2'd2,
              {32'h0, 32'h0, 32'h0000B2B2, 32'hB1B10000}, 16'hFFCC,
              -1, -1, 0, 2'b00, 1'b1, {32'h0, 32'h0, 32'h104, 32'h106}};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_bid", bid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_next_addr", next_addrwr, 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Clear the memory through the write path so the model starts known.
    for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'h00;
    for (int b = 0; b < 16; b++) begin beat_dat[b] = '0; beat_stb[b] = 4'hF; end
    for (int k = 0; k < MEM_BYTES / 64; k++) do_burst(4'd0, k * 64, 4'd15, 3'd2, 2'd1, -1, -1, 0, 0);
    check_mem("init_mem");

    foreach (v[k]) begin
      for (int b = 0; b < 16; b++) begin
        beat_dat[b] = (b < 4) ? v[k].d[b] : v[k].d[3] + b;
        beat_stb[b] = (b < 4) ? v[k].s[b] : 4'hF;
      end
      do_burst(v[k].id, v[k].a, v[k].len, v[k].sz, v[k].bt,
               v[k].bad_wid, v[k].bad_last, 0, v[k].bdelay);
      chk({v[k].nm, "_bresp"}, cap_bresp, v[k].exp_resp);
      if (v[k].chk_a)
        for (int b = 0; b <= int'(v[k].len) && b < 4; b++)
          chk({v[k].nm, "_addr"}, cap_addr[b], v[k].exp_a[b]);
      check_mem({v[k].nm, "_mem"});
    end

    dbg_chk("word_10", 32'h10, 32'h11111111);
    dbg_chk("word_1c", 32'h1E, 32'h44444444);
    dbg_chk("word_40", 32'h40, 32'h0000BBAA);
    dbg_chk("word_80_untouched", 32'h80, 32'h0);
    dbg_chk("word_3fc", 32'h3FC, 32'h5A5A5A5A);
    dbg_chk("word_60", 32'h60, 32'h66666666);
    dbg_chk("word_64_blocked", 32'h64, 32'h0);
    dbg_chk("dbg_oor", MEM_BYTES, 32'h0);
    dbg_chk("dbg_oor_high", 32'hFFFFFFFC, 32'h0);
    @(posedge clk); #1;

    // AW and first W beat in the same cycle: W must stall one cycle.
    awvalid = 1'b1; awid = 4'd13; awaddr = 32'h200; awlen = 4'd0; awsize = 3'd2; awburst = 2'd1;
    wvalid = 1'b1; wdata = 32'h12345678; wstrb = 4'hF; wid = 4'd13; wlast = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!awready && n < 100) begin @(posedge clk); #1; @(negedge clk); n++; end
      if (!awready) timeout("sim_aw");
    end
    chk("aw_w_same_stall", wready, 0);
    @(posedge clk); #1; awvalid = 1'b0;
    @(negedge clk);
    chk("w_after_aw", wready, 1);
    chk("w_after_aw_addr", next_addrwr, 32'h200);
    @(posedge clk); #1; wvalid = 1'b0; wlast = 1'b0;
    {mm[32'h203], mm[32'h202], mm[32'h201], mm[32'h200]} = 32'h12345678;
    b_phase(0);
    chk("sim_bresp", cap_bresp, 2'b00);
    chk("sim_bid", cap_bid, 4'd13);
    dbg_chk("sim_word", 32'h200, 32'h12345678);

    // Reset while beat 2 of an 8-beat burst is on the bus.
    aw_send(4'd5, 32'h300, 4'd7, 3'd2, 2'd1);
    w_beat(32'hF0F0F0F0, 4'hF, 4'd5, 1'b0, ga);
    w_beat(32'hF1F1F1F1, 4'hF, 4'd5, 1'b0, ga);
    wvalid = 1'b1; wdata = 32'hF2F2F2F2; wstrb = 4'hF; wid = 4'd5;
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_wready", wready, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    @(posedge clk); #1;
    resetn = 1'b1; wvalid = 1'b0;
    {mm[32'h303], mm[32'h302], mm[32'h301], mm[32'h300]} = 32'hF0F0F0F0;
    {mm[32'h307], mm[32'h306], mm[32'h305], mm[32'h304]} = 32'hF1F1F1F1;
    seen_b = 0;
    repeat (6) begin @(negedge clk); if (bvalid) seen_b = 1; @(posedge clk); #1; end
    chk("mid_rst_no_b", seen_b, 0);
    @(negedge clk);
    chk("mid_rst_idle", awready, 1);
    @(posedge clk); #1;
    check_mem("mid_rst_mem");

    // Randomized bursts against the model.
    for (int t = 0; t < 40; t++) begin
      rid  = 4'($urandom);
      rsz  = ($urandom_range(9, 0) == 0) ? 3'd3 : 3'($urandom_range(2, 0));
      rbt  = ($urandom_range(19, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      rlen = 4'($urandom);
      if (rbt == 2'd2 && $urandom_range(9, 0) < 7) rlen = 4'((2 << $urandom_range(3, 0)) - 1);
      ra   = $urandom_range(MEM_BYTES + 32, 0);
      rbw  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(rlen, 0)) : -1;
      rbl  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(rlen, 0)) : -1;
      for (int b = 0; b < 16; b++) begin beat_dat[b] = $urandom; beat_stb[b] = 4'($urandom); end
      do_burst(rid, ra, rlen, rsz, rbt, rbw, rbl, 2, $urandom_range(3, 0));
      check_mem("rand_mem");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
